rstk_ctrl: RTL

Sequencer for the Viterbi decoder's two-bank reverse (LIFO) stack. It counts decoded bits from the traceback unit, drives the stack's bank-select toggle every BLOCK_LEN bits, and generates valid/first/last framing for the bit-reversed output stream. It also drains the final block of a frame, handles a short final block by padding, and flags protocol errors. It sits between the traceback unit and the output interface, alongside the reverse stack.

---
 rtl/rstk_ctrl_if.sv | 24 ++
 rtl/rstk_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rstk_ctrl_if.sv
// Handshake bundle between the traceback/output side (master) and the
// reverse-stack sequencer rstk_ctrl (slave).
interface rstk_ctrl_if;
    logic frame_start;
    logic frame_end;
    logic dec_valid;
    logic stack_toggle;
    logic rev_valid;
    logic rev_first;
    logic rev_last;
    logic busy;
    logic err_gap;
    logic err_len;

    modport master (
        output frame_start, frame_end, dec_valid,
        input  stack_toggle, rev_valid, rev_first, rev_last, busy, err_gap, err_len
    );

    modport slave (
        input  frame_start, frame_end, dec_valid,
        output stack_toggle, rev_valid, rev_first, rev_last, busy, err_gap, err_len
    );
endinterface

// File: rtl/rstk_ctrl.sv
// Bank sequencer and bit-reversed output framing for the Viterbi two-bank reverse stack.
// Define RSTK_CTRL_STATS_EN to build the blk_cnt completed-block counter.
module rstk_ctrl #(
    parameter int BLOCK_LEN = 21,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    rstk_ctrl_if.slave  bus
`ifdef RSTK_CTRL_STATS_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] pad_len;
    logic             ending;

    logic start;
    logic fin;
    logic wrap;
    logic pop_valid;
    logic pop_first;
    logic pop_last;

    assign start = bus.frame_start & bus.dec_valid;
    assign fin   = bus.frame_end & bus.dec_valid;
    assign wrap  = (phase == LAST);

    // Qualifiers of the bit the stack pops at the coming edge.
    always_comb begin
        pop_valid = 1'b0;
        pop_first = 1'b0;
        pop_last  = 1'b0;
        case (state)
            STREAM: begin
                pop_valid = 1'b1;
                pop_first = (phase == '0);
            end
            DRAIN: begin
                pop_valid = (phase >= pad_len);
                pop_first = (phase == pad_len);
                pop_last  = wrap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            phase            <= '0;
            pad_len          <= '0;
            ending           <= 1'b0;
            bus.stack_toggle <= 1'b1;
            bus.rev_valid    <= 1'b0;
            bus.rev_first    <= 1'b0;
            bus.rev_last     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.err_gap      <= 1'b0;
            bus.err_len      <= 1'b0;
        end else if (start) begin
            // New frame or abort: accepted bit sits at phase 0, bank select is held.
            state         <= FILL;
            phase         <= CNT_W'(1);
            ending        <= fin;
            pad_len       <= LAST;
            bus.busy      <= 1'b1;
            bus.rev_valid <= 1'b0;
            bus.rev_first <= 1'b0;
            bus.rev_last  <= 1'b0;
            bus.err_gap   <= 1'b0;
            bus.err_len   <= fin;
        end else begin
            bus.rev_valid <= pop_valid;
            bus.rev_first <= pop_first;
            bus.rev_last  <= pop_last;
            if (state != IDLE) begin
                phase <= wrap ? '0 : phase + CNT_W'(1);
                if (wrap) bus.stack_toggle <= ~bus.stack_toggle;
            end
            case (state)
                FILL, STREAM: begin
                    // Once frame_end is seen the rest of the block is padding.
                    if (!ending) begin
                        if (!bus.dec_valid) bus.err_gap <= 1'b1;
                        if (fin) begin
                            ending  <= 1'b1;
                            pad_len <= LAST - phase;
                            if (!wrap) bus.err_len <= 1'b1;
                        end
                    end
                    if (wrap) state <= (ending || fin) ? DRAIN : STREAM;
                end
                DRAIN: begin
                    if (wrap) begin
                        state    <= IDLE;
                        ending   <= 1'b0;
                        bus.busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RSTK_CTRL_STATS_EN
    // A block completes whenever a popping state wraps; the final pop there is always valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt <= '0;
        end else if (start) begin
            blk_cnt <= '0;
        end else if ((state == STREAM || state == DRAIN) && wrap && blk_cnt != 16'hFFFF) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule
